cv32e40p_rf_ecc_scrubber: RTL and testbench



---
 rtl/cv32e40p_rf_ecc_scrubber.sv | 194 +++++++++++++++++++
 tb/tb_cv32e40p_rf_ecc_scrubber.sv | 482 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40p_rf_ecc_scrubber.sv
// Background SEC scrubber for the Hamming-protected register file.
// Walks x1..x(NUM_REGS-1), writes back single-bit corrections, counts uncorrectable words.
module cv32e40p_rf_ecc_scrubber #(
    parameter int NUM_REGS       = 32,
    parameter int SCRUB_INTERVAL = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        scrub_en_i,
    output logic [4:0]  raddr_o,
    input  logic [37:0] rdata_i,
    input  logic        core_we_i,
    input  logic [4:0]  core_waddr_i,
    output logic        wreq_o,
    input  logic        wgnt_i,
    output logic [4:0]  waddr_o,
    output logic [37:0] wdata_o,
    output logic [15:0] corr_cnt_o,
    output logic [15:0] uncorr_cnt_o,
    output logic        uncorr_err_o,
    output logic [4:0]  uncorr_addr_o,
    output logic        pass_done_o
);

    // state   | meaning
    // S_WAIT  | interval counter running down to the next scrub
    // S_READ  | ptr on the scrub read port, codeword captured into cw_q
    // S_CHECK | syndrome evaluated on cw_q, count / write-back decision
    // S_WB    | corrected codeword offered to the RF write port until granted
    typedef enum logic [1:0] {S_WAIT, S_READ, S_CHECK, S_WB} state_t;

    localparam int CNT_W = (SCRUB_INTERVAL > 1) ? $clog2(SCRUB_INTERVAL) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SCRUB_INTERVAL - 1);
    localparam logic [4:0] LAST_REG = 5'(NUM_REGS - 1);

    state_t            state_q, state_d;
    logic [4:0]        ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [37:0]       cw_q, cw_d;
    logic              wreq_q, wreq_d;
    logic [4:0]        waddr_q, waddr_d;
    logic [37:0]       wdata_q, wdata_d;
    logic [15:0]       corr_q, corr_d;
    logic [15:0]       uncorr_q, uncorr_d;
    logic              uerr_q, uerr_d;
    logic [4:0]        uaddr_q, uaddr_d;
    logic              pass_q, pass_d;

    logic [5:0]        syn;
    logic [37:0]       cw_fix;
    logic              correctable;
    logic              race;
    logic [4:0]        ptr_next;
    logic              wrap;

    // Syndrome is the XOR of the 1-based positions of all set bits.
    always_comb begin
        syn = '0;
        for (int i = 0; i < 38; i++) begin
            if (cw_q[i]) syn = syn ^ 6'(i + 1);
        end
    end

    always_comb begin
        cw_fix = cw_q;
        for (int i = 0; i < 38; i++) begin
            cw_fix[i] = cw_q[i] ^ (syn == 6'(i + 1));
        end
    end

    assign correctable = (syn != 6'd0) && (syn <= 6'd38);
    assign race        = core_we_i && (core_waddr_i == ptr_q);
    assign wrap        = (ptr_q == LAST_REG);
    assign ptr_next    = wrap ? 5'd1 : ptr_q + 5'd1;

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        cw_d     = cw_q;
        wreq_d   = wreq_q;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        corr_d   = corr_q;
        uncorr_d = uncorr_q;
        uerr_d   = 1'b0;
        uaddr_d  = uaddr_q;
        pass_d   = 1'b0;

        if (!scrub_en_i) begin
            state_d = S_WAIT;
            cnt_d   = CNT_RELOAD;
            wreq_d  = 1'b0;
        end else begin
            case (state_q)
                S_WAIT: begin
                    if (cnt_q == '0) state_d = S_READ;
                    else             cnt_d   = cnt_q - 1'b1;
                end
                S_READ: begin
                    if (race) begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_RELOAD;
                    end else begin
                        cw_d    = rdata_i;
                        state_d = S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (race) begin
                        // sample is stale; same register is retried next time
                        state_d = S_WAIT;
                        cnt_d   = CNT_RELOAD;
                    end else if (syn == 6'd0) begin
                        ptr_d   = ptr_next;
                        pass_d  = wrap;
                        state_d = S_WAIT;
                        cnt_d   = CNT_RELOAD;
                    end else if (correctable) begin
                        corr_d  = (corr_q == 16'hFFFF) ? corr_q : corr_q + 16'd1;
                        wdata_d = cw_fix;
                        waddr_d = ptr_q;
                        wreq_d  = 1'b1;
                        state_d = S_WB;
                    end else begin
                        uncorr_d = (uncorr_q == 16'hFFFF) ? uncorr_q : uncorr_q + 16'd1;
                        uerr_d   = 1'b1;
                        uaddr_d  = ptr_q;
                        ptr_d    = ptr_next;
                        pass_d   = wrap;
                        state_d  = S_WAIT;
                        cnt_d    = CNT_RELOAD;
                    end
                end
                S_WB: begin
                    // a grant beats a same-cycle core write to the same register
                    if (wgnt_i || race) begin
                        wreq_d  = 1'b0;
                        ptr_d   = ptr_next;
                        pass_d  = wrap;
                        state_d = S_WAIT;
                        cnt_d   = CNT_RELOAD;
                    end
                end
                default: begin
                    state_d = S_WAIT;
                    cnt_d   = CNT_RELOAD;
                    wreq_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_WAIT;
            ptr_q    <= 5'd1;
            cnt_q    <= CNT_RELOAD;
            cw_q     <= '0;
            wreq_q   <= 1'b0;
            waddr_q  <= 5'd1;
            wdata_q  <= '0;
            corr_q   <= '0;
            uncorr_q <= '0;
            uerr_q   <= 1'b0;
            uaddr_q  <= '0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            cw_q     <= cw_d;
            wreq_q   <= wreq_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            corr_q   <= corr_d;
            uncorr_q <= uncorr_d;
            uerr_q   <= uerr_d;
            uaddr_q  <= uaddr_d;
            pass_q   <= pass_d;
        end
    end

    assign raddr_o       = ptr_q;
    assign wreq_o        = wreq_q;
    assign waddr_o       = waddr_q;
    assign wdata_o       = wdata_q;
    assign corr_cnt_o    = corr_q;
    assign uncorr_cnt_o  = uncorr_q;
    assign uncorr_err_o  = uerr_q;
    assign uncorr_addr_o = uaddr_q;
    assign pass_done_o   = pass_q;

endmodule

// File: tb/tb_cv32e40p_rf_ecc_scrubber.sv
// Scoreboard bench for the RF ECC scrubber: a register-file model answers the read port,
// expected pointer steps, write-backs and uncorrectable events are queued and matched.
module tb_cv32e40p_rf_ecc_scrubber;

    logic        clk;
    logic        rst_n;
    logic        scrub_en;
    logic [4:0]  raddr;
    logic [37:0] rdata;
    logic        core_we;
    logic [4:0]  core_waddr;
    logic        wreq;
    logic        wgnt;
    logic [4:0]  waddr;
    logic [37:0] wdata;
    logic [15:0] corr_cnt;
    logic [15:0] uncorr_cnt;
    logic        uncorr_err;
    logic [4:0]  uncorr_addr;
    logic        pass_done;

    logic [37:0] rf    [32];
    logic [37:0] clean [32];
    logic        gnt_en;
    logic        chk_ptr;

    logic [42:0] exp_wb_q  [$];
    logic [4:0]  exp_unc_q [$];
    logic [4:0]  exp_ptr_q [$];

    int vectors;
    int miscompares;
    int pass_cnt;
    int wreq_cycles;

    logic [4:0]  mon_prev;
    logic [42:0] mon_wb;
    logic [4:0]  mon_a;

    cv32e40p_rf_ecc_scrubber #(.NUM_REGS(32), .SCRUB_INTERVAL(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .scrub_en_i    (scrub_en),
        .raddr_o       (raddr),
        .rdata_i       (rdata),
        .core_we_i     (core_we),
        .core_waddr_i  (core_waddr),
        .wreq_o        (wreq),
        .wgnt_i        (wgnt),
        .waddr_o       (waddr),
        .wdata_o       (wdata),
        .corr_cnt_o    (corr_cnt),
        .uncorr_cnt_o  (uncorr_cnt),
        .uncorr_err_o  (uncorr_err),
        .uncorr_addr_o (uncorr_addr),
        .pass_done_o   (pass_done)
    );

    assign rdata = rf[raddr];
    assign wgnt  = wreq & gnt_en;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [37:0] encode(input logic [31:0] d);
        logic [37:0] cw;
        int j;
        logic p;
        cw = '0;
        j = 0;
        for (int i = 0; i < 38; i++) begin
            if (((i + 1) & i) != 0) begin
                cw[i] = d[j];
                j++;
            end
        end
        for (int k = 0; k < 6; k++) begin
            p = 1'b0;
            for (int i = 0; i < 38; i++) begin
                if ((((i + 1) >> k) & 1) == 1 && (i + 1) != (1 << k)) p = p ^ cw[i];
            end
            cw[(1 << k) - 1] = p;
        end
        return cw;
    endfunction

    function automatic logic [37:0] flip(input logic [37:0] cw, input int idx);
        logic [37:0] r;
        r = cw;
        r[idx] = ~r[idx];
        return r;
    endfunction

    // Matches DUT events against the queues at every falling edge.
    task automatic monitor();
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mon_prev = raddr;
            end else begin
                if (pass_done) pass_cnt++;
                if (wreq) wreq_cycles++;
                if (chk_ptr && raddr !== mon_prev) begin
                    vectors++;
                    if (exp_ptr_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL ptr_seq: raddr_o moved to %0d, no step expected", raddr);
                    end else begin
                        mon_a = exp_ptr_q.pop_front();
                        if (raddr !== mon_a) begin
                            miscompares++;
                            $display("FAIL ptr_seq: raddr_o=%0d expected %0d", raddr, mon_a);
                        end
                    end
                end
                mon_prev = raddr;
                if (wreq && wgnt) begin
                    vectors++;
                    if (exp_wb_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL writeback: unexpected write addr=%0d data=%h", waddr, wdata);
                    end else begin
                        mon_wb = exp_wb_q.pop_front();
                        if ({waddr, wdata} !== mon_wb) begin
                            miscompares++;
                            $display("FAIL writeback: got addr=%0d data=%h expected addr=%0d data=%h",
                                     waddr, wdata, mon_wb[42:38], mon_wb[37:0]);
                        end
                    end
                    rf[waddr] = wdata;
                end
                if (uncorr_err) begin
                    vectors++;
                    if (exp_unc_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL uncorr_event: unexpected pulse addr=%0d", uncorr_addr);
                    end else begin
                        mon_a = exp_unc_q.pop_front();
                        if (uncorr_addr !== mon_a) begin
                            miscompares++;
                            $display("FAIL uncorr_event: uncorr_addr_o=%0d expected %0d", uncorr_addr, mon_a);
                        end
                    end
                end
            end
        end
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        scrub_en   = 1'b0;
        core_we    = 1'b0;
        core_waddr = '0;
        gnt_en     = 1'b1;
        chk_ptr    = 1'b0;
        exp_wb_q.delete();
        exp_unc_q.delete();
        exp_ptr_q.delete();
        for (int r = 0; r < 32; r++) begin
            clean[r] = encode($urandom);
            rf[r]    = clean[r];
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        pass_cnt    = 0;
        wreq_cycles = 0;
    endtask

    task automatic wait_queues(input int budget);
        for (int c = 0; c < budget && (exp_wb_q.size() + exp_unc_q.size() + exp_ptr_q.size()) != 0; c++)
            @(negedge clk);
    endtask

    task automatic wait_wreq(input int budget);
        for (int c = 0; c < budget && wreq !== 1'b1; c++) @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        vectors += 4;
        if (raddr !== 5'd1 || waddr !== 5'd1) begin
            miscompares++;
            $display("FAIL reset_addr: raddr_o=%0d waddr_o=%0d expected 1/1", raddr, waddr);
        end
        if (wreq !== 1'b0 || wdata !== 38'd0 || uncorr_err !== 1'b0 || pass_done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: wreq=%b wdata=%h uerr=%b pass=%b expected zeros",
                     wreq, wdata, uncorr_err, pass_done);
        end
        if (corr_cnt !== 16'd0 || uncorr_cnt !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_cnt: corr=%0d uncorr=%0d expected 0/0", corr_cnt, uncorr_cnt);
        end
        if (uncorr_addr !== 5'd0) begin
            miscompares++;
            $display("FAIL reset_uaddr: uncorr_addr_o=%0d expected 0", uncorr_addr);
        end
    endtask

    task automatic test_clean_pass();
        do_reset();
        for (int r = 2; r < 32; r++) exp_ptr_q.push_back(5'(r));
        exp_ptr_q.push_back(5'd1);
        chk_ptr  = 1'b1;
        scrub_en = 1'b1;
        wait_queues(400);
        chk_ptr = 1'b0;
        vectors += 4;
        if (exp_ptr_q.size() != 0) begin
            miscompares++;
            $display("FAIL clean_pass_timeout: %0d pointer steps missing", exp_ptr_q.size());
        end
        if (pass_cnt != 1) begin
            miscompares++;
            $display("FAIL clean_pass_done: pulses=%0d expected 1", pass_cnt);
        end
        if (wreq_cycles != 0) begin
            miscompares++;
            $display("FAIL clean_wreq: wreq_o high %0d cycles expected 0", wreq_cycles);
        end
        if (corr_cnt !== 16'd0 || uncorr_cnt !== 16'd0) begin
            miscompares++;
            $display("FAIL clean_counters: corr=%0d uncorr=%0d expected 0/0", corr_cnt, uncorr_cnt);
        end
    endtask

    task automatic test_correctable();
        do_reset();
        rf[5] = flip(clean[5], 2);
        rf[6] = flip(clean[6], 20);
        exp_wb_q.push_back({5'd5, clean[5]});
        exp_wb_q.push_back({5'd6, clean[6]});
        scrub_en = 1'b1;
        wait_queues(200);
        vectors += 2;
        if (exp_wb_q.size() != 0) begin
            miscompares++;
            $display("FAIL corr_data_timeout: %0d write-backs missing", exp_wb_q.size());
        end
        if (corr_cnt !== 16'd2 || uncorr_cnt !== 16'd0) begin
            miscompares++;
            $display("FAIL corr_data_cnt: corr=%0d uncorr=%0d expected 2/0", corr_cnt, uncorr_cnt);
        end
    endtask

    task automatic test_parity();
        do_reset();
        rf[7] = flip(clean[7], 31);
        exp_wb_q.push_back({5'd7, clean[7]});
        scrub_en = 1'b1;
        wait_queues(200);
        vectors += 2;
        if (exp_wb_q.size() != 0) begin
            miscompares++;
            $display("FAIL corr_parity_timeout: write-back missing");
        end
        if (corr_cnt !== 16'd1) begin
            miscompares++;
            $display("FAIL corr_parity_cnt: corr=%0d expected 1", corr_cnt);
        end
    endtask

    task automatic test_miscorrection();
        logic [37:0] bad;
        do_reset();
        bad = flip(flip(clean[9], 36), 37);
        rf[9] = bad;
        exp_wb_q.push_back({5'd9, flip(bad, 2)});
        scrub_en = 1'b1;
        wait_queues(200);
        vectors += 2;
        if (exp_wb_q.size() != 0) begin
            miscompares++;
            $display("FAIL miscorr_a_timeout: write-back missing");
        end
        if (corr_cnt !== 16'd1 || uncorr_cnt !== 16'd0) begin
            miscompares++;
            $display("FAIL miscorr_a_cnt: corr=%0d uncorr=%0d expected 1/0", corr_cnt, uncorr_cnt);
        end

        do_reset();
        bad = flip(flip(clean[9], 32), 37);
        rf[9] = bad;
        exp_wb_q.push_back({5'd9, flip(bad, 6)});
        scrub_en = 1'b1;
        wait_queues(200);
        vectors += 2;
        if (exp_wb_q.size() != 0) begin
            miscompares++;
            $display("FAIL miscorr_b_timeout: write-back missing");
        end
        if (corr_cnt !== 16'd1) begin
            miscompares++;
            $display("FAIL miscorr_b_cnt: corr=%0d expected 1", corr_cnt);
        end
    endtask

    task automatic test_uncorrectable();
        do_reset();
        rf[9] = flip(flip(flip(clean[9], 35), 36), 37);
        exp_unc_q.push_back(5'd9);
        scrub_en = 1'b1;
        wait_queues(200);
        repeat (3) @(negedge clk);
        vectors += 4;
        if (exp_unc_q.size() != 0) begin
            miscompares++;
            $display("FAIL uncorr_timeout: uncorr_err_o pulse missing");
        end
        if (uncorr_cnt !== 16'd1 || corr_cnt !== 16'd0) begin
            miscompares++;
            $display("FAIL uncorr_cnt: uncorr=%0d corr=%0d expected 1/0", uncorr_cnt, corr_cnt);
        end
        if (uncorr_addr !== 5'd9) begin
            miscompares++;
            $display("FAIL uncorr_addr: uncorr_addr_o=%0d expected 9", uncorr_addr);
        end
        if (wreq_cycles != 0) begin
            miscompares++;
            $display("FAIL uncorr_wreq: wreq_o high %0d cycles expected 0", wreq_cycles);
        end
    endtask

    task automatic test_grant_stall();
        do_reset();
        gnt_en = 1'b0;
        rf[3] = flip(clean[3], 10);
        exp_wb_q.push_back({5'd3, clean[3]});
        scrub_en = 1'b1;
        wait_wreq(100);
        for (int k = 0; k < 5; k++) begin
            vectors++;
            if (wreq !== 1'b1 || waddr !== 5'd3 || wdata !== clean[3]) begin
                miscompares++;
                $display("FAIL grant_stall_hold: cycle %0d wreq=%b addr=%0d data=%h expected 1/3/%h",
                         k, wreq, waddr, wdata, clean[3]);
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1 gnt_en = 1'b1;
        wait_queues(20);
        @(negedge clk);
        vectors += 3;
        if (exp_wb_q.size() != 0) begin
            miscompares++;
            $display("FAIL grant_stall_timeout: write-back missing");
        end
        if (wreq !== 1'b0) begin
            miscompares++;
            $display("FAIL grant_stall_release: wreq_o=%b after grant expected 0", wreq);
        end
        if (corr_cnt !== 16'd1) begin
            miscompares++;
            $display("FAIL grant_stall_cnt: corr=%0d expected 1", corr_cnt);
        end
    endtask

    task automatic test_core_race();
        do_reset();
        rf[3] = flip(clean[3], 12);
        scrub_en = 1'b1;
        for (int c = 0; c < 100 && raddr !== 5'd3; c++) @(negedge clk);
        repeat (5) @(posedge clk);
        #1;
        core_we    = 1'b1;
        core_waddr = 5'd3;
        @(posedge clk);
        #1 core_we = 1'b0;
        @(negedge clk);
        vectors += 2;
        if (raddr !== 5'd3 || wreq !== 1'b0) begin
            miscompares++;
            $display("FAIL race_discard: raddr_o=%0d wreq=%b expected 3/0", raddr, wreq);
        end
        if (corr_cnt !== 16'd0) begin
            miscompares++;
            $display("FAIL race_count: corr=%0d expected 0", corr_cnt);
        end
        exp_wb_q.push_back({5'd3, clean[3]});
        wait_queues(50);
        vectors += 2;
        if (exp_wb_q.size() != 0) begin
            miscompares++;
            $display("FAIL race_retry_timeout: retry write-back missing");
        end
        if (corr_cnt !== 16'd1) begin
            miscompares++;
            $display("FAIL race_retry_cnt: corr=%0d expected 1", corr_cnt);
        end
    endtask

    task automatic test_en_drop_wb();
        do_reset();
        gnt_en = 1'b0;
        rf[5] = flip(clean[5], 2);
        scrub_en = 1'b1;
        wait_wreq(100);
        @(posedge clk);
        #1 scrub_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        vectors += 2;
        if (wreq !== 1'b0 || raddr !== 5'd5) begin
            miscompares++;
            $display("FAIL en_drop_wb: wreq=%b raddr_o=%0d expected 0/5", wreq, raddr);
        end
        if (corr_cnt !== 16'd1) begin
            miscompares++;
            $display("FAIL en_drop_cnt: corr=%0d expected 1", corr_cnt);
        end
    endtask

    task automatic test_reset_mid_wb();
        do_reset();
        gnt_en = 1'b0;
        rf[5] = flip(clean[5], 2);
        scrub_en = 1'b1;
        wait_wreq(100);
        vectors++;
        if (wreq !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_wb_setup: wreq_o=%b expected 1", wreq);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors += 3;
        if (wreq !== 1'b0 || raddr !== 5'd1 || waddr !== 5'd1 || wdata !== 38'd0) begin
            miscompares++;
            $display("FAIL rst_wb_port: wreq=%b raddr=%0d waddr=%0d wdata=%h expected 0/1/1/0",
                     wreq, raddr, waddr, wdata);
        end
        if (corr_cnt !== 16'd0 || uncorr_cnt !== 16'd0) begin
            miscompares++;
            $display("FAIL rst_wb_cnt: corr=%0d uncorr=%0d expected 0/0", corr_cnt, uncorr_cnt);
        end
        if (uncorr_err !== 1'b0 || uncorr_addr !== 5'd0 || pass_done !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_wb_flags: uerr=%b uaddr=%0d pass=%b expected zeros",
                     uncorr_err, uncorr_addr, pass_done);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        pass_cnt    = 0;
        wreq_cycles = 0;
        mon_prev    = '0;
        rst_n       = 1'b0;
        scrub_en    = 1'b0;
        core_we     = 1'b0;
        core_waddr  = '0;
        gnt_en      = 1'b1;
        chk_ptr     = 1'b0;
        fork
            monitor();
        join_none
        test_reset();
        test_clean_pass();
        test_correctable();
        test_parity();
        test_miscorrection();
        test_uncorrectable();
        test_grant_stall();
        test_core_race();
        test_en_drop_wb();
        test_reset_mid_wb();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
